// File: rtl/dmem_wbuf_ctrl.sv
// rtl/dmem_wbuf_ctrl.sv - CPU data-memory store buffer with blocking load controller
// Define DMEM_WBUF_FWD_EN to forward load data from buffered stores.
module dmem_wbuf_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_dm,
    input  logic        re_dm,
    input  logic [31:0] alu_out,
    input  logic [31:0] wd_dm,
    output logic [31:0] rd_dm,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_WR, RD_REQ, RD_DONE} state_t;
    state_t state, state_nxt;

    logic [29:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [29:0]   ld_addr;
    logic [31:0]   rd_q;

    logic [29:0] word;
    logic        load_req, push, pop, wr_active, hit, load_go, take_fwd;
    logic        lsb_unused;

    assign word       = alu_out[31:2];
    assign lsb_unused = ^alu_out[1:0];
    // A simultaneous store and load is treated as a store only.
    assign load_req   = re_dm && !we_dm;
    assign wr_active  = (state == IDLE && count != '0) || state == WAIT_WR;
    assign push       = we_dm && count != FULL;
    assign pop        = wr_active && mem_ack;
    assign load_go    = load_req && !hit;

`ifdef DMEM_WBUF_FWD_EN
    logic [31:0] fwd_data;
    assign take_fwd = load_req && hit;
`else
    assign take_fwd = 1'b0;
`endif

    // Oldest-to-youngest scan so the last match seen is the youngest store.
    always_comb begin
        logic [PW-1:0] idx;
        hit = 1'b0;
        idx = head;
`ifdef DMEM_WBUF_FWD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && buf_addr[idx] == word) begin
                hit = 1'b1;
`ifdef DMEM_WBUF_FWD_EN
                fwd_data = buf_data[idx];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A write ack arriving in the same cycle as the load lets the read start directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_go) state_nxt = (wr_active && !mem_ack) ? WAIT_WR : RD_REQ;
            WAIT_WR: if (mem_ack) state_nxt = RD_REQ;
            RD_REQ:  if (mem_ack) state_nxt = RD_DONE;
            RD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = we_dm && count == FULL;
        if (wr_active) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = buf_addr[head];
            mem_wdata = buf_data[head];
        end else if (state == RD_REQ) begin
            mem_req  = 1'b1;
            mem_addr = ld_addr;
        end
        case (state)
            IDLE:            if (load_req && !take_fwd) stall = 1'b1;
            WAIT_WR, RD_REQ: stall = 1'b1;
            default:         ;
        endcase
    end

`ifdef DMEM_WBUF_FWD_EN
    assign rd_dm = (state == IDLE && take_fwd) ? fwd_data : rd_q;
`else
    assign rd_dm = rd_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ld_addr <= '0;
            rd_q    <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (state == IDLE) ld_addr <= word;
            if (state == RD_REQ && mem_ack) rd_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            buf_addr[tail] <= word;
            buf_data[tail] <= wd_dm;
        end
    end
endmodule

// File: tb/tb_dmem_wbuf_ctrl.sv
// tb/tb_dmem_wbuf_ctrl.sv - self-checking bench for dmem_wbuf_ctrl
module tb_dmem_wbuf_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, we_dm, re_dm;
    logic [31:0] alu_out, wd_dm, rd_dm, mem_wdata, mem_rdata;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [29:0] mem_addr;

    logic        resp_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    logic        ack_en = 1'b0;
    logic        ack_rand = 1'b0;
    int          fix_delay = 1;
    int          resp_cnt = 0;
    int          txn_delay = 0;

    int checks = 0;
    int failures = 0;

    logic [61:0] wr_log [$];
    logic        we_seq [$];
    logic [61:0] exp_q [$];
    logic [31:0] mem_model [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];

    assign mem_ack   = resp_ack | man_ack;
    assign mem_rdata = resp_rdata;

    dmem_wbuf_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .we_dm(we_dm), .re_dm(re_dm), .alu_out(alu_out),
        .wd_dm(wd_dm), .rd_dm(rd_dm), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing memory: acks a request txn_delay cycles after it first appears.
    always @(posedge clk) begin
        #2;
        if (resp_ack) begin
            resp_ack = 1'b0;
            resp_cnt = 0;
        end else if (ack_en && rst && mem_req) begin
            resp_cnt++;
            if (resp_cnt == 1) txn_delay = ack_rand ? int'($urandom_range(0, 3)) : fix_delay;
            if (resp_cnt > txn_delay) begin
                resp_ack   = 1'b1;
                resp_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hDEADBEEF;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rst && mem_ack && mem_req) begin
            we_seq.push_back(mem_we);
            if (mem_we) begin
                wr_log.push_back({mem_addr, mem_wdata});
                mem_model[mem_addr] = mem_wdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] exp_load(input logic [29:0] w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return 32'hDEADBEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
        we_dm = 1'b1; alu_out = a; wd_dm = d; stalls = 0;
        @(negedge clk);
        while (stall && stalls < 300) begin stalls++; @(negedge clk); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL store_timeout addr=%h stall=%b required 0", a, stall); end
        tick();
        we_dm = 1'b0;
        exp_q.push_back({a[31:2], d});
        ref_mem[a[31:2]] = d;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int stalls);
        re_dm = 1'b1; alu_out = a; stalls = 0;
        @(negedge clk);
        while (stall && stalls < 300) begin stalls++; @(negedge clk); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL load_timeout addr=%h stall=%b required 0", a, stall); end
        d = rd_dm;
        tick();
        re_dm = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (mem_req && n < 500) begin n++; @(negedge clk); end
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL drain_timeout mem_req=%b required 0", mem_req); end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; we_dm = 1'b0; re_dm = 1'b0; alu_out = '0; wd_dm = '0;
        tick(); tick();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (rd_dm !== 32'h0) begin failures++; $display("FAIL reset_rd_dm got=%h exp=0", rd_dm); end
        checks++; if (mem_addr !== 30'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_fill_stall();
        int st;
        int lb;
        lb = wr_log.size();
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), st);
            checks++; if (st != 0) begin failures++; $display("FAIL fill_no_stall idx=%0d stalls=%0d exp=0", i, st); end
        end
        we_dm = 1'b1; alu_out = 32'h110; wd_dm = 32'hA4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_stall cyc=%0d got=%b exp=1", c, stall); end
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'h40 || mem_wdata !== 32'hA0) begin
                failures++; $display("FAIL head_write req=%b we=%b addr=%h data=%h exp 1 1 40 a0", mem_req, mem_we, mem_addr, mem_wdata);
            end
            tick();
        end
        man_ack = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ack_cycle_stall got=%b exp=1", stall); end
        tick();
        man_ack = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL after_ack_stall got=%b exp=0", stall); end
        tick();
        we_dm = 1'b0;
        exp_q.push_back({30'h44, 32'hA4});
        ref_mem[30'h44] = 32'hA4;
        @(negedge clk);
        checks++;
        if (mem_addr !== 30'h41 || mem_wdata !== 32'hA1) begin
            failures++; $display("FAIL next_head addr=%h data=%h exp 41 a1", mem_addr, mem_wdata);
        end
        tick();
        ack_en = 1'b1; ack_rand = 1'b0; fix_delay = 1;
        drain();
        checks++; if (wr_log.size() != lb + 5) begin failures++; $display("FAIL fill_write_count got=%0d exp=%0d", wr_log.size() - lb, 5); end
    endtask

    task automatic test_forward();
        int st;
        logic [31:0] d, exp_d;
        int sb;
        ack_en = 1'b0;
        do_store(32'h200, 32'h11, st);
        do_store(32'h200, 32'h22, st);
        exp_d = exp_load(30'h80);
`ifdef DMEM_WBUF_FWD_EN
        re_dm = 1'b1; alu_out = 32'h200;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%b exp=0", stall); end
        checks++; if (rd_dm !== exp_d) begin failures++; $display("FAIL fwd_data got=%h exp=%h", rd_dm, exp_d); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL fwd_no_read mem_we=%b exp=1", mem_we); end
        tick();
        re_dm = 1'b0;
        ack_en = 1'b1; fix_delay = 1;
        drain();
        sb = 0; d = '0;
`else
        ack_en = 1'b1; fix_delay = 1;
        sb = we_seq.size();
        do_load(32'h200, d, st);
        checks++; if (d !== exp_d) begin failures++; $display("FAIL nofwd_data got=%h exp=%h", d, exp_d); end
        checks++; if (st < 3) begin failures++; $display("FAIL nofwd_stall stalls=%0d exp>=3", st); end
        checks++;
        if (we_seq.size() != sb + 3 || we_seq[sb] !== 1'b1 || we_seq[sb+1] !== 1'b1 || we_seq[sb+2] !== 1'b0) begin
            failures++; $display("FAIL nofwd_order txns=%0d exp=3 (write,write,read)", we_seq.size() - sb);
        end
`endif
    endtask

    task automatic test_load_miss();
        int st, sb;
        logic [31:0] d;
        ack_en = 1'b1; ack_rand = 1'b0; fix_delay = 3;
        sb = we_seq.size();
        do_load(32'h300, d, st);
        checks++; if (st != 5) begin failures++; $display("FAIL miss_latency stalls=%0d exp=5", st); end
        checks++; if (d !== exp_load(30'hC0)) begin failures++; $display("FAIL miss_data got=%h exp=%h", d, exp_load(30'hC0)); end
        checks++;
        if (we_seq.size() != sb + 1 || we_seq[sb] !== 1'b0) begin
            failures++; $display("FAIL miss_txn txns=%0d exp=1 read", we_seq.size() - sb);
        end
        @(negedge clk);
        checks++; if (rd_dm !== d) begin failures++; $display("FAIL rd_hold got=%h exp=%h", rd_dm, d); end
        tick();
    endtask

    task automatic test_load_during_write();
        int st, sb, lb;
        logic [31:0] d;
        ack_en = 1'b1; ack_rand = 1'b0; fix_delay = 2;
        sb = we_seq.size(); lb = wr_log.size();
        do_store(32'h500, 32'h5A5A0001, st);
        do_load(32'h400, d, st);
        checks++; if (d !== exp_load(30'h100)) begin failures++; $display("FAIL wr_then_rd_data got=%h exp=%h", d, exp_load(30'h100)); end
        checks++;
        if (we_seq.size() != sb + 2 || we_seq[sb] !== 1'b1 || we_seq[sb+1] !== 1'b0) begin
            failures++; $display("FAIL wr_then_rd_order txns=%0d exp=2 (write,read)", we_seq.size() - sb);
        end
        checks++;
        if (wr_log.size() <= lb || wr_log[lb] !== {30'h140, 32'h5A5A0001}) begin
            failures++; $display("FAIL wr_then_rd_write got_count=%0d exp write 140/5a5a0001", wr_log.size() - lb);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++) do_store(32'h700 + 32'(4 * i), 32'h77000000 + 32'(i), st);
        re_dm = 1'b1; alu_out = 32'h600;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mid_load_stall got=%b exp=1", stall); end
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h180) begin
            failures++; $display("FAIL mid_rd_req req=%b we=%b addr=%h exp 1 0 180", mem_req, mem_we, mem_addr);
        end
        tick();
        rst = 1'b0; re_dm = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.pop_back(); exp_q.pop_back();
        ref_mem.delete(30'h1C1); ref_mem.delete(30'h1C2);
        for (int c = 0; c < 2; c++) begin
            if (c == 1) man_ack = 1'b1;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || stall !== 1'b0 || rd_dm !== 32'h0) begin
                failures++; $display("FAIL post_reset cyc=%0d req=%b stall=%b rd=%h exp 0 0 0", c, mem_req, stall, rd_dm);
            end
            tick();
            man_ack = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_store(32'h780 + 32'(4 * i), 32'h78000000 + 32'(i), st);
            checks++; if (st != 0) begin failures++; $display("FAIL post_reset_empty idx=%0d stalls=%0d exp=0", i, st); end
        end
        ack_en = 1'b1; fix_delay = 1;
        drain();
    endtask

    task automatic test_random();
        int st, lb, eb;
        logic [31:0] a, d, e;
        ack_en = 1'b1; ack_rand = 1'b1;
        lb = wr_log.size(); eb = exp_q.size();
        for (int i = 0; i < 20; i++) begin
            a = 32'h800 + 32'($urandom_range(0, 15)) * 4;
            do_store(a, $urandom, st);
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int i = 0; i < 4; i++) begin
            a = 32'h800 + 32'($urandom_range(0, 15)) * 4;
            e = exp_load(a[31:2]);
            do_load(a, d, st);
            checks++; if (d !== e) begin failures++; $display("FAIL rand_load addr=%h got=%h exp=%h", a, d, e); end
        end
        drain();
        checks++; if (wr_log.size() - lb != 20) begin failures++; $display("FAIL rand_write_count got=%0d exp=20", wr_log.size() - lb); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (wr_log[lb+i] !== exp_q[eb+i]) begin
                failures++; $display("FAIL rand_order idx=%0d got=%h exp=%h", i, wr_log[lb+i], exp_q[eb+i]);
            end
        end
        ack_rand = 1'b0;
    endtask

    task automatic test_total_log();
        checks++;
        if (wr_log.size() != exp_q.size()) begin
            failures++; $display("FAIL total_writes got=%0d exp=%0d", wr_log.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i] !== exp_q[i]) begin failures++; $display("FAIL total_order idx=%0d got=%h exp=%h", i, wr_log[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_forward();
        test_load_miss();
        test_load_during_write();
        test_reset_mid();
        test_random();
        test_total_log();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
